// File: rtl/or_arb_pkg.sv
// Shared types and helpers for the round-robin OR arbiter.
// Holds the FSM state type, ID width rule and the rotating pick.
package or_arb_pkg;

    typedef enum logic {IDLE, RESP} state_t;

    localparam int MAX_REQ   = 16;
    localparam int MAX_IDX_W = 4;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } pick_t;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First valid index at or after ptr, wrapping modulo n.
    function automatic pick_t rr_pick(
        input logic [MAX_IDX_W-1:0] ptr,
        input logic [MAX_REQ-1:0]   req,
        input int                   n
    );
        pick_t p;
        int    j;
        p = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n && !p.found) begin
                j = (int'(ptr) + k) % n;
                if (req[MAX_IDX_W'(j)]) begin
                    p.found = 1'b1;
                    p.idx   = MAX_IDX_W'(j);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/or_unit.sv
// Shared combinational OR datapath.
// Instantiated once behind the arbiter's operand mux.
module or_unit #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    assign y = a | b;

endmodule

// File: rtl/rr_or_arbiter.sv
// Round-robin arbiter sharing one OR unit among NUM_REQ requesters.
// Registered response with ID; accepts a new grant while draining.
module rr_or_arbiter
    import or_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 8,
    localparam int ID_W    = id_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id
);

    state_t              state;
    state_t              state_n;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     ptr_n;
    logic [ID_W-1:0]     g;
    pick_t               pick;
    logic                can_accept;
    logic                xfer;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [DATA_W-1:0]   or_y;

    assign can_accept = (state == IDLE) || rsp_ready;
    assign pick       = rr_pick(MAX_IDX_W'(ptr), MAX_REQ'(req_valid), NUM_REQ);
    assign g          = ID_W'(pick.idx);
    assign xfer       = can_accept && pick.found;

    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[g] = 1'b1;
    end

    assign op_a = req_a[int'(g)*DATA_W +: DATA_W];
    assign op_b = req_b[int'(g)*DATA_W +: DATA_W];

    or_unit #(
        .DATA_W (DATA_W)
    ) u_or (
        .a (op_a),
        .b (op_b),
        .y (or_y)
    );

    assign ptr_n = (int'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (xfer) state_n = RESP;
            RESP:    if (rsp_ready && !xfer) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Data and ID only move on a transfer; they hold after draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_id   <= '0;
            ptr      <= '0;
        end else if (xfer) begin
            rsp_data <= or_y;
            rsp_id   <= g;
            ptr      <= ptr_n;
        end
    end

    assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_rr_or_arbiter.sv
// Directed scoreboard bench for rr_or_arbiter.
// Expected responses are queued at grant time and popped on output.
module tb_rr_or_arbiter;

    typedef struct {
        logic [3:0] id;
        logic [7:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;

    int   vectors;
    int   miscompares;
    exp_t sb[$];
    logic [7:0] xa;
    logic [7:0] rot_or [4];

    rr_or_arbiter #(
        .NUM_REQ (4),
        .DATA_W  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [7:0] a,
                           input logic [7:0] b);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
    endtask

    task automatic push(input logic [3:0] id, input logic [7:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic check_rsp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: got empty scoreboard want entry", tag);
        end else begin
            e = sb.pop_front();
            cmp({tag, "_valid"}, 32'(rsp_valid), 32'd1);
            cmp({tag, "_id"}, 32'(rsp_id), 32'(e.id));
            cmp({tag, "_data"}, 32'(rsp_data), 32'(e.data));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rot_or      = '{8'h11, 8'h22, 8'h44, 8'h88};
        rst_n       = 1'b1;
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        rsp_ready   = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        cmp("rst_valid", 32'(rsp_valid), 32'd0);
        cmp("rst_data", 32'(rsp_data), 32'd0);
        cmp("rst_id", 32'(rsp_id), 32'd0);
        cmp("rst_ready", 32'(req_ready), 32'd0);
        cmp("rst_ptr", 32'(dut.ptr), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // single requester
        req_valid = 4'b0100;
        set_ops(2, 8'h0F, 8'h30);
        rsp_ready = 1'b1;
        #1 cmp("single_ready", 32'(req_ready), 32'b0100);
        push(4'd2, 8'h3F);
        tick();
        check_rsp("single_rsp");
        cmp("single_ptr", 32'(dut.ptr), 32'd3);
        req_valid = '0;
        #1 cmp("single_noreq", 32'(req_ready), 32'd0);
        tick();
        cmp("drain_valid", 32'(rsp_valid), 32'd0);
        cmp("drain_hold", 32'(rsp_data), 32'h3F);

        // wrap ptr 3 -> 0
        req_valid = 4'b1000;
        set_ops(3, 8'h00, 8'h07);
        #1 cmp("wrap_ready", 32'(req_ready), 32'b1000);
        push(4'd3, 8'h07);
        tick();
        check_rsp("wrap_rsp");
        cmp("wrap_ptr", 32'(dut.ptr), 32'd0);

        // rotation, all requesters valid
        req_valid = 4'b1111;
        req_a     = 32'h0804_0201;
        req_b     = 32'h8040_2010;
        for (int k = 0; k < 5; k++) begin
            #1 cmp("rot_ready", 32'(req_ready), 32'(1 << (k % 4)));
            push(4'(k % 4), rot_or[k % 4]);
            tick();
            check_rsp("rot_rsp");
        end
        cmp("rot_ptr", 32'(dut.ptr), 32'd1);

        // backpressure
        req_valid = 4'b1010;
        set_ops(1, 8'h01, 8'h80);
        set_ops(3, 8'h40, 8'h04);
        #1 cmp("bp_grant", 32'(req_ready), 32'b0010);
        push(4'd1, 8'h81);
        tick();
        check_rsp("bp_rsp");
        rsp_ready = 1'b0;
        #1 cmp("bp_ready0", 32'(req_ready), 32'd0);
        for (int h = 0; h < 3; h++) begin
            tick();
            cmp("bp_hold_v", 32'(rsp_valid), 32'd1);
            cmp("bp_hold_id", 32'(rsp_id), 32'd1);
            cmp("bp_hold_d", 32'(rsp_data), 32'h81);
            cmp("bp_hold_rdy", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1 cmp("bp_release", 32'(req_ready), 32'b1000);
        push(4'd3, 8'h44);
        tick();
        check_rsp("bp_next");
        cmp("bp_ptr", 32'(dut.ptr), 32'd0);

        // X propagation through the OR
        req_valid = 4'b0001;
        set_ops(0, 8'bxxxx_0000, 8'b1111_0000);
        #1 cmp("x1_ready", 32'(req_ready), 32'b0001);
        push(4'd0, 8'hF0);
        tick();
        check_rsp("x1_rsp");
        xa = 8'b0000_xxxx;
        set_ops(0, xa, 8'h00);
        #1 cmp("x2_ready", 32'(req_ready), 32'b0001);
        push(4'd0, xa | 8'h00);
        tick();
        check_rsp("x2_rsp");
        cmp("x2_ptr", 32'(dut.ptr), 32'd1);

        // drop-out while blocked, then go idle
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        #1 cmp("drop_ready", 32'(req_ready), 32'd0);
        tick();
        cmp("drop_hold_v", 32'(rsp_valid), 32'd1);
        cmp("drop_hold_d", 32'(rsp_data), 32'(xa | 8'h00));
        req_valid = '0;
        cmp("drop_ptr", 32'(dut.ptr), 32'd1);
        rsp_ready = 1'b1;
        #1 cmp("drop_noready", 32'(req_ready), 32'd0);
        tick();
        cmp("idle_valid", 32'(rsp_valid), 32'd0);
        cmp("idle_state", 32'(dut.state == or_arb_pkg::IDLE), 32'd1);
        cmp("idle_ptr", 32'(dut.ptr), 32'd1);
        cmp("idle_sb", 32'(sb.size()), 32'd0);

        // async reset mid-response
        req_valid = 4'b0010;
        set_ops(1, 8'hF0, 8'h00);
        #1 cmp("pre_rst_ready", 32'(req_ready), 32'b0010);
        push(4'd1, 8'hF0);
        tick();
        check_rsp("pre_rst_rsp");
        rsp_ready = 1'b0;
        req_valid = '0;
        cmp("pre_rst_ptr", 32'(dut.ptr), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        cmp("arst_valid", 32'(rsp_valid), 32'd0);
        cmp("arst_data", 32'(rsp_data), 32'd0);
        cmp("arst_id", 32'(rsp_id), 32'd0);
        cmp("arst_ptr", 32'(dut.ptr), 32'd0);
        cmp("arst_state", 32'(dut.state == or_arb_pkg::IDLE), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
